// File: rtl/dec2hex_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dec2hex_pkg
// Description : Shared widths, FSM state encoding and BCD helper for dec2hex.
// Revision    : 1.0 - initial release
// ============================================================================
package dec2hex_pkg;

    localparam int BCD_W  = 16;
    localparam int BIN_W  = 14;
    localparam int N_ITER = 14;
    localparam int CNT_W  = 4;
    localparam int WORK_W = BCD_W + BIN_W;
    localparam int N_NIB  = BCD_W / 4;

    typedef enum logic [3:0] {
        IDLE   = 4'b0001,
        CHECK  = 4'b0010,
        SHIFT  = 4'b0100,
        ADJUST = 4'b1000
    } state_t;

    // True when every nibble holds a legal decimal digit.
    function automatic logic bcd_is_valid(input logic [BCD_W-1:0] bcd);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < N_NIB; i++) begin
            if (bcd[i*4 +: 4] > 4'd9) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_nibble_adjust.sv
`default_nettype none
// ============================================================================
// Module      : bcd_nibble_adjust
// Description : Reverse double-dabble digit correction (subtract 3 if >= 8).
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_nibble_adjust (
    input  logic [3:0] i_nibble,
    output logic [3:0] o_nibble
);

    assign o_nibble = (i_nibble >= 4'd8) ? (i_nibble - 4'd3) : i_nibble;

endmodule
`default_nettype wire

// File: rtl/dec2hex.sv
`default_nettype none
// ============================================================================
// Module      : dec2hex
// Description : 4-digit packed BCD to 14-bit binary, reverse double-dabble.
// Revision    : 1.0 - initial release
// ============================================================================
module dec2hex
    import dec2hex_pkg::*;
(
    input  logic             clk_50m,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BCD_W-1:0] bcd_data,
    output logic [BIN_W-1:0] bin_data,
    output logic             busy,
    output logic             done,
    output logic             err
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WORK_W-1:0]   r_work;
    logic [CNT_W-1:0]    r_iter;
    logic [WORK_W-1:0]   w_work_shr;
    logic [BCD_W-1:0]    w_bcd_adj;
    logic                w_last;
    logic                w_valid;

    assign w_work_shr = {1'b0, r_work[WORK_W-1:1]};
    assign w_last     = (r_iter == CNT_W'(N_ITER - 1));
    assign w_valid    = bcd_is_valid(r_work[WORK_W-1:BIN_W]);
    assign busy       = (r_state != IDLE);

    for (genvar g = 0; g < N_NIB; g++) begin : g_nib
        bcd_nibble_adjust u_adj (
            .i_nibble (r_work[BIN_W + g*4 +: 4]),
            .o_nibble (w_bcd_adj[g*4 +: 4])
        );
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = CHECK;
            CHECK:   w_state_nxt = w_valid ? SHIFT : IDLE;
            SHIFT:   w_state_nxt = w_last ? IDLE : ADJUST;
            ADJUST:  w_state_nxt = SHIFT;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath and registered outputs; done defaults low so it only pulses.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            r_work   <= '0;
            r_iter   <= '0;
            bin_data <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_work <= {bcd_data, {BIN_W{1'b0}}};
                        r_iter <= '0;
                        err    <= 1'b0;
                    end
                end
                CHECK: begin
                    if (!w_valid) begin
                        err      <= 1'b1;
                        done     <= 1'b1;
                        bin_data <= '0;
                    end
                end
                SHIFT: begin
                    r_work <= w_work_shr;
                    r_iter <= r_iter + CNT_W'(1);
                    if (w_last) begin
                        bin_data <= w_work_shr[BIN_W-1:0];
                        done     <= 1'b1;
                    end
                end
                ADJUST: begin
                    r_work[WORK_W-1:BIN_W] <= w_bcd_adj;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dec2hex.sv
`default_nettype none
// ============================================================================
// Module      : tb_dec2hex
// Description : Self-checking bench for dec2hex (vectors, sweep, random).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dec2hex;

    logic        clk_50m = 1'b0;
    logic        rst_n   = 1'b1;
    logic        start   = 1'b0;
    logic [15:0] bcd_data = '0;
    logic [13:0] bin_data;
    logic        busy;
    logic        done;
    logic        err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] bcd;
        logic [13:0] bin;
        bit          err;
    } vec_t;

    vec_t vecs[10];

    dec2hex dut (
        .clk_50m  (clk_50m),
        .rst_n    (rst_n),
        .start    (start),
        .bcd_data (bcd_data),
        .bin_data (bin_data),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #10 clk_50m = ~clk_50m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Reference: decimal value of the digits, or error if any digit exceeds 9.
    function automatic void model(input logic [15:0] b, output int v, output bit e);
        int d [4];
        e = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d[i] = int'((b >> (4 * i)) & 16'hF);
            if (d[i] > 9) e = 1'b1;
        end
        v = e ? 0 : d[3] * 1000 + d[2] * 100 + d[1] * 10 + d[0];
    endfunction

    // Waits for done after an accepting edge; returns edges counted (0 = timeout).
    task automatic wait_done(output int lat, output bit stable, input logic [13:0] prev);
        lat    = 0;
        stable = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk_50m);
            @(negedge clk_50m);
            if (done) begin
                lat = k;
                break;
            end
            if (bin_data !== prev || !busy) stable = 1'b0;
        end
    endtask

    task automatic run_conv(input logic [15:0] bcd, input int exp_bin, input bit exp_err, input string name);
        int          lat;
        bit          stable;
        logic [13:0] prev;
        prev = bin_data;
        @(negedge clk_50m);
        start    = 1'b1;
        bcd_data = bcd;
        @(posedge clk_50m);
        #1;
        start    = 1'b0;
        bcd_data = 16'($urandom);
        @(negedge clk_50m);
        check({name, " busy_after_accept"}, busy, 1);
        wait_done(lat, stable, prev);
        check({name, " latency"}, lat, exp_err ? 1 : 28);
        check({name, " bin"}, bin_data, exp_bin);
        check({name, " err"}, err, exp_err);
        check({name, " busy_in_done"}, busy, 0);
        check({name, " hold_mid_conv"}, stable, 1);
        @(posedge clk_50m);
        @(negedge clk_50m);
        check({name, " done_one_cycle"}, done, 0);
        check({name, " err_held"}, err, exp_err);
    endtask

    initial begin
        int          lat;
        int          v;
        bit          e;
        bit          stable;
        bit          no_done;
        logic [15:0] b;

        vecs[0] = '{16'h9999, 14'h270F, 1'b0};
        vecs[1] = '{16'h1234, 14'h04D2, 1'b0};
        vecs[2] = '{16'h0000, 14'h0000, 1'b0};
        vecs[3] = '{16'h12A4, 14'h0000, 1'b1};
        vecs[4] = '{16'h0001, 14'h0001, 1'b0};
        vecs[5] = '{16'h9000, 14'h2328, 1'b0};
        vecs[6] = '{16'hA000, 14'h0000, 1'b1};
        vecs[7] = '{16'h0999, 14'h03E7, 1'b0};
        vecs[8] = '{16'h000F, 14'h0000, 1'b1};
        vecs[9] = '{16'h5678, 14'h162E, 1'b0};

        #3 rst_n = 1'b0;
        #2;
        check("reset bin", bin_data, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset err", err, 0);
        @(negedge clk_50m);
        @(negedge clk_50m);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_conv(vecs[i].bcd, int'(vecs[i].bin), vecs[i].err, $sformatf("vec%0d_%h", i, vecs[i].bcd));
        end

        // Back-to-back with start held high and data toggling while busy.
        @(negedge clk_50m);
        start    = 1'b1;
        bcd_data = 16'h0042;
        @(posedge clk_50m);
        #1 bcd_data = 16'h0100;
        wait_done(lat, stable, bin_data);
        check("b2b first latency", lat, 28);
        check("b2b first bin", bin_data, 14'h002A);
        @(posedge clk_50m);
        #1 bcd_data = 16'h0042;
        wait_done(lat, stable, bin_data);
        check("b2b second latency", lat, 28);
        check("b2b second bin", bin_data, 14'h0064);
        check("b2b second err", err, 0);
        start = 1'b0;

        // Reset during ADJUST of a 5678 conversion.
        @(negedge clk_50m);
        start    = 1'b1;
        bcd_data = 16'h5678;
        @(posedge clk_50m);
        #1 start = 1'b0;
        @(posedge clk_50m);
        @(posedge clk_50m);
        #3 rst_n = 1'b0;
        #1;
        check("midreset bin", bin_data, 0);
        check("midreset busy", busy, 0);
        check("midreset done", done, 0);
        check("midreset err", err, 0);
        @(negedge clk_50m);
        @(negedge clk_50m);
        rst_n   = 1'b1;
        no_done = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_50m);
            if (done || busy) no_done = 1'b0;
        end
        check("midreset no_done", no_done, 1);
        run_conv(16'h5678, 14'h162E, 1'b0, "after_reset_5678");

        // Strided sweep across the whole decimal range.
        for (int n = 0; n < 10000; n += 11) begin
            b = {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
            run_conv(b, n, 1'b0, $sformatf("sweep_%0d", n));
        end

        // Random stimulus, half forced to legal digits.
        for (int r = 0; r < 150; r++) begin
            if (r % 2 == 0) begin
                b = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                     4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            end else begin
                b = 16'($urandom);
            end
            model(b, v, e);
            run_conv(b, v, e, $sformatf("rand_%h", b));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dec2hex.md
DEC2HEX -- requirements
Module: dec2hex

Interface
REQ-001 The block SHALL have no parameters; widths are fixed: 4 BCD digits in, 14-bit binary out.
REQ-002 clk_50m  input  1  system clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  conversion request; sampled only in IDLE.
REQ-005 bcd_data  input  16  packed BCD, digit 3 in [15:12] down to digit 0 in [3:0]; sampled on the edge that accepts start.
REQ-006 bin_data  output  14  binary result; unsigned, 0..9999.
REQ-007 busy  output  1  high while a conversion is in progress (any state other than IDLE).
REQ-008 done  output  1  one-cycle completion pulse.
REQ-009 err  output  1  invalid-BCD flag; valid while done is high and held until the next accepted start.

Function
REQ-010 The algorithm SHALL be reverse double-dabble:
  - work register {bcd[15:0], bin[13:0]};
  - each iteration shifts the whole register right by 1, with bcd[0] moving into bin[13];
  - after every shift except the 14th, each BCD nibble >= 8 has 3 subtracted.
REQ-011 The FSM SHALL have the states IDLE, CHECK, SHIFT and ADJUST.
REQ-012 IDLE -> CHECK SHALL occur when start=1 on an edge in IDLE; that edge latches bcd_data into the work register, clears bin and the iteration counter, and clears err.
REQ-013 In CHECK, any nibble > 9 SHALL cause:
  - next state IDLE;
  - err=1, done=1 for one cycle;
  - bin_data=0.
  Otherwise the next state is SHIFT.
REQ-014 In SHIFT, the block SHALL perform the shift and increment the 4-bit iteration counter.
  - If the counter was 13: next state IDLE, bin_data <= shifted bin, done=1 for one cycle.
  - Otherwise: next state ADJUST.
REQ-015 ADJUST SHALL apply the per-nibble correction and always return to SHIFT.
REQ-016 Latency SHALL be measured from the accepting edge T:
  - valid input: done is high in the cycle after edge T+28 (14 SHIFT + 13 ADJUST + 1 CHECK);
  - invalid input: done is high in the cycle after edge T+1.
REQ-017 start SHALL be ignored while busy=1; bcd_data changes after the accepting edge SHALL NOT affect the result.
REQ-018 A start present during the done cycle (state IDLE) SHALL be accepted, giving back-to-back conversions with no dead cycle.
REQ-019 bin_data SHALL hold its last value until the next conversion completes; it is never updated mid-conversion.
REQ-020 done SHALL be 0 in every cycle other than the completion cycle; busy SHALL be 0 in the done cycle.
REQ-021 All nibble arithmetic SHALL be 4-bit unsigned; the subtraction cannot underflow because it applies only to values >= 8.

Reset
REQ-022 On rst_n low, asynchronously:
  - state=IDLE;
  - bin_data=0, busy=0, done=0, err=0;
  - work register and iteration counter = 0.
REQ-023 Reset asserted mid-conversion SHALL abort it with no done pulse; the first conversion after release starts cleanly from IDLE.

Structure
REQ-024 Shared package dec2hex_pkg SHALL hold:
  - state encoding (one-hot, 4 bits: IDLE, CHECK, SHIFT, ADJUST);
  - BCD_W=16, BIN_W=14, N_ITER=14.
REQ-025 One combinational sub-module, bcd_nibble_adjust, SHALL implement the 4-bit ">= 8 then subtract 3" correction; it is instantiated 4 times.
REQ-026 The FSM, work register, counter and output registers SHALL reside in dec2hex.

Verification
REQ-027 bcd_data=16'h9999, start pulse -> done after edge T+28, bin_data=14'h270F, err=0.
REQ-028 16'h1234 -> bin_data=14'h04D2. 16'h0000 -> bin_data=0.
REQ-029 16'h12A4 -> done after edge T+1, err=1, bin_data=0, busy low in the done cycle.
REQ-030 start held high continuously with bcd_data alternating 16'h0042 / 16'h0100 -> results 14'h002A then 14'h0064, back-to-back, start ignored while busy.
REQ-031 rst_n pulsed low during ADJUST of a 16'h5678 conversion -> all outputs 0 immediately, no done pulse; a subsequent 16'h5678 conversion -> 14'h162E.
REQ-032 Exhaustive sweep 0000..9999 -> bin_data equals the decimal value for every input; err=0 throughout.
